// File: rtl/sift_scan_ctrl.sv
// Raster-scan sequencer for the SIFT blur/DoG front end: tracks pixel position,
// drives line-buffer addressing/rotation and flags complete interior KMAX x KMAX windows.
module sift_scan_ctrl #(
  parameter int COLS = 640,
  parameter int ROWS = 480,
  parameter int KMAX = 7,
  parameter int CW   = 10,
  parameter int RW   = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          down_ready,
  output logic          lb_wr_en,
  output logic [CW-1:0] lb_wr_addr,
  output logic [2:0]    lb_sel,
  output logic          win_valid,
  output logic [CW-1:0] ctr_col,
  output logic [RW-1:0] ctr_row,
  output logic          frame_done,
  output logic          busy
);

  localparam int R = KMAX / 2;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [2:0]    SEL_LAST = 3'(KMAX - 2);
  localparam logic [CW-1:0] COL_MIN  = CW'(2 * R);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2 * R);
  localparam logic [CW-1:0] COL_OFF  = CW'(R);
  localparam logic [RW-1:0] ROW_OFF  = RW'(R);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [2:0]    sel;
  logic          accept;
  logic          col_end;
  logic          row_end;
  logic          win_hit;

  assign in_ready   = down_ready & (state != DONE);
  assign accept     = in_valid & in_ready;
  assign col_end    = (col == COL_LAST);
  assign row_end    = (row == ROW_LAST);
  assign lb_wr_en   = accept;
  assign lb_wr_addr = col;
  assign lb_sel     = sel;
  // A window is complete once the pixel lands at least 2R rows and columns in.
  assign win_hit    = accept & (row >= ROW_MIN) & (col >= COL_MIN);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (accept && col_end && row_end) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      sel <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        if (row_end) begin
          row <= '0;
          sel <= '0;
        end else begin
          row <= row + 1'b1;
          sel <= (sel == SEL_LAST) ? 3'd0 : sel + 3'd1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Window stage: pulse one cycle after the completing pixel, centre held between pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      ctr_col   <= '0;
      ctr_row   <= '0;
    end else begin
      win_valid <= win_hit;
      if (win_hit) begin
        ctr_col <= col - COL_OFF;
        ctr_row <= row - ROW_OFF;
      end
    end
  end

endmodule

// File: tb/tb_sift_scan_ctrl.sv
// Directed bench for sift_scan_ctrl on a reduced 16x12 frame with a 7x7 kernel.
module tb_sift_scan_ctrl;

  localparam int COLS = 16;
  localparam int ROWS = 12;
  localparam int KMAX = 7;
  localparam int CW   = 10;
  localparam int RW   = 9;
  localparam int R    = KMAX / 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          down_ready;
  logic          lb_wr_en;
  logic [CW-1:0] lb_wr_addr;
  logic [2:0]    lb_sel;
  logic          win_valid;
  logic [CW-1:0] ctr_col;
  logic [RW-1:0] ctr_row;
  logic          frame_done;
  logic          busy;

  int n_vec;
  int n_err;

  sift_scan_ctrl #(.COLS(COLS), .ROWS(ROWS), .KMAX(KMAX), .CW(CW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .down_ready(down_ready), .lb_wr_en(lb_wr_en), .lb_wr_addr(lb_wr_addr),
    .lb_sel(lb_sel), .win_valid(win_valid), .ctr_col(ctr_col), .ctr_row(ctr_row),
    .frame_done(frame_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; down_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0d expected 0", busy); end
    n_vec++; if (win_valid !== 1'b0) begin n_err++; $display("FAIL reset_win: got %0d expected 0", win_valid); end
    in_valid = 1'b1;
    repeat (20) tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL pre_reset_busy: got %0d expected 1", busy); end
    n_vec++; if (lb_wr_addr !== CW'(4)) begin n_err++; $display("FAIL pre_reset_addr: got %0d expected 4", lb_wr_addr); end
    n_vec++; if (lb_sel !== 3'd1) begin n_err++; $display("FAIL pre_reset_sel: got %0d expected 1", lb_sel); end
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %0d expected 0", busy); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL mid_reset_done: got %0d expected 0", frame_done); end
    n_vec++; if (win_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_win: got %0d expected 0", win_valid); end
    n_vec++; if (ctr_col !== '0 || ctr_row !== '0) begin n_err++; $display("FAIL mid_reset_ctr: got (%0d,%0d) expected (0,0)", ctr_row, ctr_col); end
    n_vec++; if (lb_sel !== 3'd0) begin n_err++; $display("FAIL mid_reset_sel: got %0d expected 0", lb_sel); end
    n_vec++; if (lb_wr_addr !== '0) begin n_err++; $display("FAIL mid_reset_addr: got %0d expected 0", lb_wr_addr); end
    n_vec++; if (in_ready !== 1'b1 || lb_wr_en !== 1'b0) begin n_err++; $display("FAIL mid_reset_hs: got rdy=%0d wr=%0d expected rdy=1 wr=0", in_ready, lb_wr_en); end
  endtask

  // Streams one full frame starting in IDLE; optionally stalls down_ready for 10 cycles at (sr,sc).
  task automatic run_frame(input int sr, input int sc);
    int wins;
    bit exp_win;
    bit last;
    wins = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (r == sr && c == sc) begin
          down_ready = 1'b0; in_valid = 1'b1;
          for (int k = 0; k < 10; k++) begin
            #1;
            n_vec++; if (in_ready !== 1'b0 || lb_wr_en !== 1'b0) begin n_err++; $display("FAIL stall_hs: got rdy=%0d wr=%0d expected 0 0", in_ready, lb_wr_en); end
            tick();
            n_vec++; if (win_valid !== 1'b0) begin n_err++; $display("FAIL stall_win: got %0d expected 0", win_valid); end
          end
          down_ready = 1'b1;
        end
        in_valid = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1 || lb_wr_en !== 1'b1) begin n_err++; $display("FAIL accept_hs r%0d c%0d: got rdy=%0d wr=%0d expected 1 1", r, c, in_ready, lb_wr_en); end
        n_vec++; if (lb_wr_addr !== CW'(c)) begin n_err++; $display("FAIL wr_addr r%0d: got %0d expected %0d", r, lb_wr_addr, c); end
        n_vec++; if (lb_sel !== 3'(r % (KMAX - 1))) begin n_err++; $display("FAIL lb_sel r%0d: got %0d expected %0d", r, lb_sel, r % (KMAX - 1)); end
        tick();
        exp_win = (r >= 2 * R) && (c >= 2 * R);
        last = (r == ROWS - 1) && (c == COLS - 1);
        n_vec++; if (win_valid !== exp_win) begin n_err++; $display("FAIL win_valid r%0d c%0d: got %0d expected %0d", r, c, win_valid, exp_win); end
        if (exp_win) begin
          wins++;
          n_vec++; if (ctr_row !== RW'(r - R) || ctr_col !== CW'(c - R)) begin n_err++; $display("FAIL win_ctr: got (%0d,%0d) expected (%0d,%0d)", ctr_row, ctr_col, r - R, c - R); end
        end
        n_vec++; if (frame_done !== last || busy !== !last) begin n_err++; $display("FAIL status r%0d c%0d: got done=%0d busy=%0d expected %0d %0d", r, c, frame_done, busy, last, !last); end
      end
    end
    n_vec++; if (wins != (ROWS - 2 * R) * (COLS - 2 * R)) begin n_err++; $display("FAIL win_count: got %0d expected %0d", wins, (ROWS - 2 * R) * (COLS - 2 * R)); end
  endtask

  task automatic test_full_frame();
    run_frame(-1, -1);
    n_vec++; if (ctr_row !== RW'(ROWS - 1 - R) || ctr_col !== CW'(COLS - 1 - R)) begin n_err++; $display("FAIL last_ctr: got (%0d,%0d) expected (%0d,%0d)", ctr_row, ctr_col, ROWS - 1 - R, COLS - 1 - R); end
  endtask

  task automatic test_frame_boundary();
    n_vec++; if (in_ready !== 1'b0 || lb_wr_en !== 1'b0) begin n_err++; $display("FAIL done_hs: got rdy=%0d wr=%0d expected 0 0", in_ready, lb_wr_en); end
    tick();
    n_vec++; if (frame_done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL idle_status: got done=%0d busy=%0d expected 0 0", frame_done, busy); end
    n_vec++; if (win_valid !== 1'b0) begin n_err++; $display("FAIL idle_win: got %0d expected 0", win_valid); end
    n_vec++; if (ctr_row !== RW'(ROWS - 1 - R) || ctr_col !== CW'(COLS - 1 - R)) begin n_err++; $display("FAIL ctr_hold: got (%0d,%0d) expected (%0d,%0d)", ctr_row, ctr_col, ROWS - 1 - R, COLS - 1 - R); end
    n_vec++; if (in_ready !== 1'b1 || lb_wr_addr !== '0 || lb_sel !== 3'd0) begin n_err++; $display("FAIL idle_first: got rdy=%0d addr=%0d sel=%0d expected 1 0 0", in_ready, lb_wr_addr, lb_sel); end
  endtask

  task automatic test_back_pressure();
    run_frame(8, 10);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    test_reset();
    test_full_frame();
    test_frame_boundary();
    test_back_pressure();
    in_valid = 1'b0;
    tick();
    n_vec++; if (frame_done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL end_idle: got done=%0d busy=%0d expected 0 0", frame_done, busy); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
